// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, ex/mem payload type and ALU op encodings
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [XLEN-1:0]   alu_out;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [XLEN-1:0]   store_data;
    } ex_mem_payload_t;

    localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SUB    = 5'b00001,
        ALU_SLL    = 5'b00010,
        ALU_SLT    = 5'b00011,
        ALU_SLTU   = 5'b00100,
        ALU_XOR    = 5'b00101,
        ALU_SRL    = 5'b00110,
        ALU_SRA    = 5'b00111,
        ALU_OR     = 5'b01000,
        ALU_AND    = 5'b01001,
        ALU_PASS_B = 5'b01010,
        ALU_EQ     = 5'b01011,
        ALU_NE     = 5'b01100,
        ALU_LT     = 5'b01101,
        ALU_GE     = 5'b01110,
        ALU_LTU    = 5'b01111,
        ALU_GEU    = 5'b10000
    } alu_op_e;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - generic 2-entry skid buffer with flush and registered ready
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             fire;

    // ready depends only on registered state, never on out_ready
    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && in_ready && !flush;
    assign fire      = main_valid_q && out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end
        end else if (fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with skid buffering and branch redirect
module ex_mem_stage #(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Flush,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [XLEN-1:0]   ALU_out_in,
    input  logic              Flag_in,
    input  logic [REG_AW-1:0] Rd_in,
    input  logic              Reg_write_in,
    input  logic              Mem_read_in,
    input  logic              Mem_write_in,
    input  logic [XLEN-1:0]   Store_data_in,
    input  logic              Is_branch_in,
    input  logic [XLEN-1:0]   Branch_target_in,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [XLEN-1:0]   ALU_result,
    output logic [REG_AW-1:0] Rd,
    output logic              Reg_write,
    output logic              Mem_read,
    output logic              Mem_write,
    output logic [XLEN-1:0]   Store_data,
    output logic              Redirect,
    output logic [XLEN-1:0]   Redirect_target
);

    // same field order as cpu_pkg::ex_mem_payload_t, sized from this instance's parameters
    localparam int PW = 2 * XLEN + REG_AW + 3;

    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   out_payload;
    logic            accept;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] target_q, target_d;

    assign in_payload = {ALU_out_in, Rd_in, Reg_write_in, Mem_read_in, Mem_write_in, Store_data_in};

    skid_buffer #(
        .WIDTH(PW)
    ) u_skid_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (Flush),
        .in_valid  (In_valid),
        .in_ready  (In_ready),
        .in_data   (in_payload),
        .out_valid (Out_valid),
        .out_ready (Out_ready),
        .out_data  (out_payload)
    );

    assign {ALU_result, Rd, Reg_write, Mem_read, Mem_write, Store_data} = out_payload;

    // redirect follows acceptance, not delivery, so memory backpressure cannot delay it
    assign accept = In_valid && In_ready && !Flush;

    always_comb begin
        redirect_d = accept && Is_branch_in && Flag_in;
        target_d   = redirect_d ? Branch_target_in : target_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            redirect_q <= redirect_d;
            target_q   <= target_d;
        end
    end

    assign Redirect        = redirect_q;
    assign Redirect_target = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage against a 2-deep FIFO model
module tb_ex_mem_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int PW     = 2 * XLEN + REG_AW + 3;

    logic              clk;
    logic              rst_n;
    logic              Flush;
    logic              In_valid;
    logic              In_ready;
    logic [XLEN-1:0]   ALU_out_in;
    logic              Flag_in;
    logic [REG_AW-1:0] Rd_in;
    logic              Reg_write_in;
    logic              Mem_read_in;
    logic              Mem_write_in;
    logic [XLEN-1:0]   Store_data_in;
    logic              Is_branch_in;
    logic [XLEN-1:0]   Branch_target_in;
    logic              Out_valid;
    logic              Out_ready;
    logic [XLEN-1:0]   ALU_result;
    logic [REG_AW-1:0] Rd;
    logic              Reg_write;
    logic              Mem_read;
    logic              Mem_write;
    logic [XLEN-1:0]   Store_data;
    logic              Redirect;
    logic [XLEN-1:0]   Redirect_target;

    ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Flush            (Flush),
        .In_valid         (In_valid),
        .In_ready         (In_ready),
        .ALU_out_in       (ALU_out_in),
        .Flag_in          (Flag_in),
        .Rd_in            (Rd_in),
        .Reg_write_in     (Reg_write_in),
        .Mem_read_in      (Mem_read_in),
        .Mem_write_in     (Mem_write_in),
        .Store_data_in    (Store_data_in),
        .Is_branch_in     (Is_branch_in),
        .Branch_target_in (Branch_target_in),
        .Out_valid        (Out_valid),
        .Out_ready        (Out_ready),
        .ALU_result       (ALU_result),
        .Rd               (Rd),
        .Reg_write        (Reg_write),
        .Mem_read         (Mem_read),
        .Mem_write        (Mem_write),
        .Store_data       (Store_data),
        .Redirect         (Redirect),
        .Redirect_target  (Redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference: a FIFO of at most two beats; outputs show the most recent head
    logic [PW-1:0]   model_q[$];
    logic [PW-1:0]   last_head = '0;
    logic            exp_redirect = 1'b0;
    logic [XLEN-1:0] exp_target = '0;

    function automatic logic [PW-1:0] offered_payload();
        return {ALU_out_in, Rd_in, Reg_write_in, Mem_read_in, Mem_write_in, Store_data_in};
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_next();
        logic acc;
        logic fire;
        if (!rst_n) begin
            model_q.delete();
            last_head    = '0;
            exp_redirect = 1'b0;
            exp_target   = '0;
            return;
        end
        fire = (model_q.size() > 0) && Out_ready;
        acc  = In_valid && (model_q.size() < 2) && !Flush;
        exp_redirect = acc && Is_branch_in && Flag_in;
        if (exp_redirect) exp_target = Branch_target_in;
        if (Flush) begin
            model_q.delete();
        end else begin
            if (fire) void'(model_q.pop_front());
            if (acc) model_q.push_back(offered_payload());
        end
        if (model_q.size() > 0) last_head = model_q[0];
    endtask

    task automatic check_outputs();
        chk("out_valid", PW'(Out_valid), PW'(model_q.size() > 0));
        chk("in_ready", PW'(In_ready), PW'(model_q.size() < 2));
        chk("payload", {ALU_result, Rd, Reg_write, Mem_read, Mem_write, Store_data}, last_head);
        chk("redirect", PW'(Redirect), PW'(exp_redirect));
        chk("redirect_target", PW'(Redirect_target), PW'(exp_target));
    endtask

    task automatic cycle();
        model_next();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_beat(input logic [XLEN-1:0] alu, input logic br, input logic flag,
                            input logic [XLEN-1:0] tgt);
        In_valid         = 1'b1;
        ALU_out_in       = alu;
        Is_branch_in     = br;
        Flag_in          = flag;
        Branch_target_in = tgt;
        Rd_in            = REG_AW'($urandom);
        Reg_write_in     = 1'($urandom);
        Mem_read_in      = 1'($urandom);
        Mem_write_in     = 1'($urandom);
        Store_data_in    = $urandom;
    endtask

    initial begin
        logic r0;
        logic r1;
        rst_n = 1'b0; Flush = 1'b0; Out_ready = 1'b0;
        set_beat(32'h1234_5678, 1'b1, 1'b1, 32'h0000_0800);
        @(negedge clk);

        // reset with a beat held on the input
        cycle();
        cycle();
        chk("rst_out_valid", PW'(Out_valid), PW'(1'b0));
        chk("rst_redirect", PW'(Redirect), PW'(1'b0));
        rst_n = 1'b1; In_valid = 1'b0;
        cycle();
        chk("post_rst_in_ready", PW'(In_ready), PW'(1'b1));
        chk("post_rst_alu", PW'(ALU_result), PW'(0));
        chk("post_rst_target", PW'(Redirect_target), PW'(0));

        // streaming
        Out_ready = 1'b1;
        set_beat(32'h10, 1'b0, 1'b0, '0); cycle();
        chk("stream0", PW'(ALU_result), PW'(32'h10));
        set_beat(32'h20, 1'b0, 1'b0, '0); cycle();
        chk("stream1", PW'(ALU_result), PW'(32'h20));
        set_beat(32'h30, 1'b0, 1'b0, '0); cycle();
        chk("stream2", PW'(ALU_result), PW'(32'h30));
        chk("stream_valid", PW'(Out_valid), PW'(1'b1));
        In_valid = 1'b0; cycle();

        // backpressure into the skid entry
        Out_ready = 1'b0;
        set_beat(32'hAAAA_0001, 1'b0, 1'b0, '0); cycle();
        set_beat(32'hBBBB_0002, 1'b0, 1'b0, '0); cycle();
        chk("bp_in_ready", PW'(In_ready), PW'(1'b0));
        chk("bp_head_a", PW'(ALU_result), PW'(32'hAAAA_0001));
        In_valid = 1'b0; Out_ready = 1'b1; cycle();
        chk("bp_head_b", PW'(ALU_result), PW'(32'hBBBB_0002));
        chk("bp_ready_back", PW'(In_ready), PW'(1'b1));
        cycle();
        chk("bp_drained", PW'(Out_valid), PW'(1'b0));

        // taken branch under backpressure, then not-taken
        Out_ready = 1'b0;
        set_beat(32'h5, 1'b1, 1'b1, 32'h0000_0400); cycle();
        chk("br_pulse", PW'(Redirect), PW'(1'b1));
        chk("br_target", PW'(Redirect_target), PW'(32'h400));
        In_valid = 1'b0; cycle();
        chk("br_pulse_end", PW'(Redirect), PW'(1'b0));
        Out_ready = 1'b1; cycle();
        Out_ready = 1'b0;
        set_beat(32'h6, 1'b1, 1'b0, 32'h0000_0400); cycle();
        chk("br_not_taken", PW'(Redirect), PW'(1'b0));
        In_valid = 1'b0; Out_ready = 1'b1; cycle();

        // flush with both entries full and a taken branch offered
        Out_ready = 1'b0;
        set_beat(32'hC, 1'b0, 1'b0, '0); cycle();
        set_beat(32'hD, 1'b0, 1'b0, '0); cycle();
        set_beat(32'hE, 1'b1, 1'b1, 32'h0000_0900); Flush = 1'b1; Out_ready = 1'b1; cycle();
        chk("flush_valid", PW'(Out_valid), PW'(1'b0));
        chk("flush_ready", PW'(In_ready), PW'(1'b1));
        chk("flush_redirect", PW'(Redirect), PW'(1'b0));
        // flush with room available still drops the branch
        cycle();
        chk("flush_redirect2", PW'(Redirect), PW'(1'b0));
        Flush = 1'b0; In_valid = 1'b0;
        repeat (3) cycle();

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            set_beat($urandom, 1'($urandom), 1'($urandom), $urandom);
            In_valid  = ($urandom_range(0, 3) != 0);
            Out_ready = ($urandom_range(0, 2) != 0);
            Flush     = ($urandom_range(0, 31) == 0);
            rst_n     = ($urandom_range(0, 1999) != 0);
            #1 r0 = In_ready;
            Out_ready = ~Out_ready;
            #1 r1 = In_ready;
            Out_ready = ~Out_ready;
            chk("in_ready_no_out_ready_path", PW'(r1), PW'(r0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register that sits directly downstream of the main ALU. It captures the ALU result and comparison flag, together with the destination-register and memory-control sideband of the instruction in execute.
- Presents the captured beat to the memory stage through a valid/ready handshake, with a 2-entry skid buffer so that execute is never combinationally stalled by memory.
- Resolves taken branches from the ALU flag and issues a one-cycle redirect to fetch.

Parameters:
- XLEN, 32, datapath width of ALU result, store data and branch target
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- Flush  in  1  kill all buffered beats and any beat offered this cycle
- In_valid  in  1  execute offers a beat
- In_ready  out  1  stage can accept a beat
- ALU_out_in  in  XLEN  ALU result
- Flag_in  in  1  ALU comparison flag
- Rd_in  in  REG_AW  destination register
- Reg_write_in  in  1  writeback enable
- Mem_read_in  in  1  load
- Mem_write_in  in  1  store
- Store_data_in  in  XLEN  rs2 value for stores
- Is_branch_in  in  1  conditional branch
- Branch_target_in  in  XLEN  computed branch target
- Out_valid  out  1  beat presented to memory stage
- Out_ready  in  1  memory stage accepts
- ALU_result  out  XLEN  buffered ALU result
- Rd  out  REG_AW
- Reg_write  out  1
- Mem_read  out  1
- Mem_write  out  1
- Store_data  out  XLEN
- Redirect  out  1  one-cycle pulse: taken branch
- Redirect_target  out  XLEN  fetch target, valid while Redirect = 1

Behaviour:
- Reset (rst_n = 0 at an edge): main_valid = skid_valid = 0, Redirect = 0; all payload outputs and Redirect_target = 0. In_ready reads 1 from the first cycle after reset.
- Payload = {ALU_out_in, Rd_in, Reg_write_in, Mem_read_in, Mem_write_in, Store_data_in}.
  - Flag_in, Is_branch_in and Branch_target_in are consumed by the branch logic only.
- In_ready = !skid_valid. The signal is purely registered-state derived, with no combinational path from Out_ready.
- Accept = In_valid && In_ready && !Flush.
- Out_valid = main_valid. Payload outputs are driven from the main register. Fire = Out_valid && Out_ready.
- Per-cycle update, with Flush = 0:
  - main empty, accept: main <= in.
  - main full, fire, skid empty, accept: main <= in.
  - main full, fire, skid full: main <= skid, skid_valid <= 0. Accept is impossible here because In_ready = 0.
  - main full, no fire, accept: skid <= in, skid_valid <= 1.
  - main full, fire, no accept, skid empty: main_valid <= 0.
  - Ordering is strictly FIFO; no beat is lost or duplicated.
- Flush = 1: main_valid <= 0, skid_valid <= 0; the beat offered this cycle is dropped. Flush has priority over every other event, including a simultaneous fire, which still counts as consumed downstream.
- Payload registers hold their last value when invalid. Payload bits are not cleared except by reset.
- Branch:
  - On Accept with Is_branch_in && Flag_in, the next cycle has Redirect = 1 and Redirect_target = Branch_target_in. Otherwise Redirect = 0 the next cycle.
  - Redirect is independent of Out_ready backpressure.
  - A branch beat offered during Flush produces no Redirect.
  - Redirect_target holds its value when Redirect = 0.
- Latency: beat accepted at edge N is visible on outputs after edge N, so Out_valid rises at N+1 when the buffer was empty.
- Throughput: 1 beat/cycle while Out_ready = 1.
- Reset mid-operation discards both buffered beats and any pending Redirect.

Decomposition:
- Shared package (cpu_pkg) holds:
  - XLEN and REG_AW constants.
  - The ex_mem payload packed type with its field order as above.
  - ALU control encodings, shared with the ALU and control decoder: ADD = 5'b00000 ... GEU = 5'b10000.
- One sub-module: skid_buffer. It is generic over WIDTH, contains the main and skid registers plus the handshake, and has flush and synchronous active-low reset.
- ex_mem_stage instantiates skid_buffer and contains only the payload packing and the branch-redirect register.

Test Plan:
1. Reset with In_valid = 1 held -> during reset Out_valid = 0 and Redirect = 0. Cycle after release, In_ready = 1 and all outputs are 0.
2. Streaming with Out_ready = 1: beats with ALU_out_in = 0x10, 0x20, 0x30 on consecutive cycles -> ALU_result shows 0x10, 0x20, 0x30 one cycle later, Out_valid continuously 1.
3. Backpressure: beat A = 0xAAAA_0001 accepted, Out_ready = 0, beat B = 0xBBBB_0002 offered -> B taken into skid, In_ready = 0 next cycle. Raising Out_ready gives A then B, and In_ready returns to 1 after A fires.
4. Taken branch: Is_branch_in = 1, Flag_in = 1, Branch_target_in = 0x0000_0400, Out_ready = 0 -> next cycle Redirect = 1 with target 0x400, pulse exactly 1 cycle. Same stimulus with Flag_in = 0 -> Redirect stays 0.
5. Flush with both entries full plus a branch beat offered (flag 1) -> next cycle Out_valid = 0, In_ready = 1, Redirect = 0, and no stale beat ever appears on the outputs.
6. Random valid/ready over 10k cycles against a scoreboard FIFO model -> in-order, lossless delivery, and In_ready never depends on same-cycle Out_ready.
